mem_arb: RTL and testbench

Single-port memory arbiter for the 5-stage pipeline. It shares one unified instruction/data RAM port between the IF stage (instruction fetch) and the MEM stage (load/store). It sequences each access over a req/ack handshake to the RAM, returns registered read data, and drives the global pipeline stall. It discards any in-flight fetch that the branch/jump flush logic kills.

---
 rtl/mem_arb_if.sv | 60 ++++++
 rtl/mem_arb.sv | 210 +++++++++++++++++++++
 tb/tb_mem_arb.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_if
// Purpose  : Bundles the memory-arbiter signals for the pipeline side (IF and
//            MEM stages, flush, stall) and the RAM side (req/ack port).
// Modports : slave  - the arbiter: takes requests and RAM responses, drives
//                     done pulses, read data, stall, RAM commands and err.
//            master - the environment (pipeline + RAM): the reverse.
// Signals  : if_req/if_addr/if_rdata/if_done        fetch channel
//            mem_req/mem_we/mem_addr/mem_wdata/
//            mem_rdata/mem_done                     load/store channel
//            flush, stall                           pipeline control
//            ram_req/ram_we/ram_addr/ram_wdata/
//            ram_rdata/ram_ack                      RAM port
//            err                                    sticky watchdog timeout
// Revision : 1.0  initial release
// ============================================================================
interface mem_arb_if #(
  parameter int DATA_W = 32
);
  // Fetch channel
  logic              if_req;
  logic [DATA_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_done;
  // Load/store channel
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_done;
  // Pipeline control
  logic              flush;
  logic              stall;
  // RAM port
  logic              ram_req;
  logic              ram_we;
  logic [DATA_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_ack;
  // Status
  logic              err;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata,
           flush, ram_rdata, ram_ack,
    output if_rdata, if_done, mem_rdata, mem_done, stall,
           ram_req, ram_we, ram_addr, ram_wdata, err
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata,
           flush, ram_rdata, ram_ack,
    input  if_rdata, if_done, mem_rdata, mem_done, stall,
           ram_req, ram_we, ram_addr, ram_wdata, err
  );
endinterface
`default_nettype wire

// File: rtl/mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb
// Purpose  : Single-port memory arbiter for the 5-stage pipeline. Shares one
//            unified instruction/data RAM port between the IF stage and the
//            MEM stage, one access at a time, MEM having strict priority.
//            Returns registered read data with one-cycle done pulses, drives
//            the global pipeline stall, discards fetches killed by flush and
//            flags a RAM that never acknowledges.
// Ports    : clk   - clock, rising edge
//            nrst  - asynchronous active-low reset
//            bus   - mem_arb_if.slave (fetch, load/store, flush/stall,
//                    RAM req/ack port, err)
// Revision : 1.0  initial release
// ============================================================================
module mem_arb #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  wire logic   clk,
  input  wire logic   nrst,
  mem_arb_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GNT_MEM = 2'd1,
    S_GNT_IF  = 2'd2,
    S_IF_DROP = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT);

  // --------------------------------------------------------------------------
  // Registered state and outputs
  // --------------------------------------------------------------------------
  state_t              r_state;
  logic                r_ram_req;
  logic                r_ram_we;
  logic [DATA_W-1:0]   r_ram_addr;
  logic [DATA_W-1:0]   r_ram_wdata;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_mem_rdata;
  logic                r_if_done;
  logic                r_mem_done;
  logic                r_err;
  logic [CNT_W-1:0]    r_wd_cnt;

  // Next-state values computed by the combinational process
  state_t              w_state;
  logic                w_ram_req;
  logic                w_ram_we;
  logic [DATA_W-1:0]   w_ram_addr;
  logic [DATA_W-1:0]   w_ram_wdata;
  logic [DATA_W-1:0]   w_if_rdata;
  logic [DATA_W-1:0]   w_mem_rdata;
  logic                w_if_done;
  logic                w_mem_done;
  logic                w_err;
  logic [CNT_W-1:0]    w_wd_cnt;

  // An ack only means something while a request is actually on the port.
  logic                w_ack;
  assign w_ack = bus.ram_ack & r_ram_req;

  // --------------------------------------------------------------------------
  // State / output register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= S_IDLE;
      r_ram_req   <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
      r_if_done   <= 1'b0;
      r_mem_done  <= 1'b0;
      r_err       <= 1'b0;
      r_wd_cnt    <= '0;
    end else begin
      r_state     <= w_state;
      r_ram_req   <= w_ram_req;
      r_ram_we    <= w_ram_we;
      r_ram_addr  <= w_ram_addr;
      r_ram_wdata <= w_ram_wdata;
      r_if_rdata  <= w_if_rdata;
      r_mem_rdata <= w_mem_rdata;
      r_if_done   <= w_if_done;
      r_mem_done  <= w_mem_done;
      r_err       <= w_err;
      r_wd_cnt    <= w_wd_cnt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and next-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    // Defaults: hold everything, done pulses last a single cycle.
    w_state     = r_state;
    w_ram_req   = r_ram_req;
    w_ram_we    = r_ram_we;
    w_ram_addr  = r_ram_addr;
    w_ram_wdata = r_ram_wdata;
    w_if_rdata  = r_if_rdata;
    w_mem_rdata = r_mem_rdata;
    w_if_done   = 1'b0;
    w_mem_done  = 1'b0;

    case (r_state)
      S_IDLE: begin
        // Requests are level signals held until their done pulse; the done
        // qualifier stops a still-held request from being granted twice.
        if (bus.mem_req && !r_mem_done) begin
          w_state     = S_GNT_MEM;
          w_ram_req   = 1'b1;
          w_ram_we    = bus.mem_we;
          w_ram_addr  = bus.mem_addr;
          w_ram_wdata = bus.mem_wdata;
        end else if (bus.if_req && !r_if_done && !bus.flush) begin
          w_state    = S_GNT_IF;
          w_ram_req  = 1'b1;
          w_ram_we   = 1'b0;
          w_ram_addr = bus.if_addr;
        end
      end

      S_GNT_MEM: begin
        if (w_ack) begin
          w_state    = S_IDLE;
          w_ram_req  = 1'b0;
          w_ram_we   = 1'b0;
          w_mem_done = 1'b1;
          // Stores leave the previous load data visible.
          if (!r_ram_we) begin
            w_mem_rdata = bus.ram_rdata;
          end
        end
      end

      S_GNT_IF: begin
        // The RAM access itself always runs to completion; a flush only
        // decides whether the returned word is delivered.
        if (w_ack) begin
          w_state   = S_IDLE;
          w_ram_req = 1'b0;
          w_ram_we  = 1'b0;
          if (!bus.flush) begin
            w_if_done  = 1'b1;
            w_if_rdata = bus.ram_rdata;
          end
        end else if (bus.flush) begin
          w_state = S_IF_DROP;
        end
      end

      S_IF_DROP: begin
        // Killed fetch: wait out the ack and throw the data away.
        if (w_ack) begin
          w_state   = S_IDLE;
          w_ram_req = 1'b0;
          w_ram_we  = 1'b0;
        end
      end

      default: begin
        w_state   = S_IDLE;
        w_ram_req = 1'b0;
        w_ram_we  = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Watchdog: counts unacknowledged request cycles. The count saturates at
  // the timeout so it can never wrap back below it while the FSM keeps
  // waiting; err is sticky until reset.
  // --------------------------------------------------------------------------
  always_comb begin
    w_wd_cnt = r_wd_cnt;
    if ((r_state == S_IDLE) || w_ack) begin
      w_wd_cnt = '0;
    end else if (r_ram_req && !bus.ram_ack && (r_wd_cnt != c_timeout)) begin
      w_wd_cnt = r_wd_cnt + 1'b1;
    end
    w_err = r_err | (w_wd_cnt == c_timeout);
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // Stall is combinational so the pipeline freezes in the same cycle a
  // request appears, and releases in the cycle its done pulse is high.
  assign bus.stall     = (bus.mem_req & ~r_mem_done)
                       | (bus.if_req & ~r_if_done & ~bus.flush);
  assign bus.ram_req   = r_ram_req;
  assign bus.ram_we    = r_ram_we;
  assign bus.ram_addr  = r_ram_addr;
  assign bus.ram_wdata = r_ram_wdata;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.if_done   = r_if_done;
  assign bus.mem_rdata = r_mem_rdata;
  assign bus.mem_done  = r_mem_done;
  assign bus.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arb
// Purpose  : Directed self-checking bench for mem_arb. A small RAM responder
//            acks after a programmable number of wait states (or never).
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_arb;

  logic clk;
  logic nrst;

  mem_arb_if #(.DATA_W(32)) bus ();

  mem_arb #(.DATA_W(32), .TIMEOUT(64), .CNT_W(7)) u_dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // RAM responder: ack after wait_n unacknowledged request cycles
  // --------------------------------------------------------------------------
  int          wait_n;
  logic        ram_en;
  logic [31:0] ram_data;
  int          ws_cnt;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) ws_cnt <= 0;
    else if (bus.ram_req && !bus.ram_ack) ws_cnt <= ws_cnt + 1;
    else ws_cnt <= 0;
  end

  assign bus.ram_ack   = ram_en && bus.ram_req && (ws_cnt == wait_n);
  assign bus.ram_rdata = ram_data;

  // Count RAM accesses (rising edges of ram_req)
  logic prev_req;
  int   n_grant;
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      prev_req <= 1'b0;
      n_grant  <= 0;
    end else begin
      prev_req <= bus.ram_req;
      if (bus.ram_req && !prev_req) n_grant <= n_grant + 1;
    end
  end

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  int n_chk;
  int n_bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ram_req"},   32'(bus.ram_req),  32'h0);
    chk({tag, "_ram_we"},    32'(bus.ram_we),   32'h0);
    chk({tag, "_ram_addr"},  bus.ram_addr,      32'h0);
    chk({tag, "_ram_wdata"}, bus.ram_wdata,     32'h0);
    chk({tag, "_if_rdata"},  bus.if_rdata,      32'h0);
    chk({tag, "_mem_rdata"}, bus.mem_rdata,     32'h0);
    chk({tag, "_if_done"},   32'(bus.if_done),  32'h0);
    chk({tag, "_mem_done"},  32'(bus.mem_done), 32'h0);
    chk({tag, "_err"},       32'(bus.err),      32'h0);
  endtask

  // Safety net: the sequence is fixed-length, this only guards against a hang.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  int g0;

  initial begin
    n_chk = 0;
    n_bad = 0;
    nrst  = 1'b0;
    wait_n   = 0;
    ram_en   = 1'b1;
    ram_data = 32'h0;
    bus.if_req    = 1'b0;
    bus.if_addr   = 32'h0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;
    bus.flush     = 1'b0;

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("rst");
    chk("rst_stall", 32'(bus.stall), 32'h0);
    #2 nrst = 1'b1;
    tick();

    // ---------------- fetch, zero wait ----------------
    wait_n   = 0;
    ram_data = 32'h8C080004;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h00400000;
    #1 chk("f0_stall_c0", 32'(bus.stall), 32'h1);
    tick();                                   // cycle 1
    chk("f0_ram_req_c1", 32'(bus.ram_req), 32'h1);
    chk("f0_ram_addr_c1", bus.ram_addr, 32'h00400000);
    chk("f0_ram_we_c1", 32'(bus.ram_we), 32'h0);
    chk("f0_if_done_c1", 32'(bus.if_done), 32'h0);
    tick();                                   // cycle 2
    chk("f0_if_done_c2", 32'(bus.if_done), 32'h1);
    chk("f0_if_rdata_c2", bus.if_rdata, 32'h8C080004);
    chk("f0_ram_req_c2", 32'(bus.ram_req), 32'h0);
    bus.if_req = 1'b0;
    tick();                                   // cycle 3
    chk("f0_if_done_c3", 32'(bus.if_done), 32'h0);
    chk("f0_stall_c3", 32'(bus.stall), 32'h0);

    // ---------------- collision: MEM load first, then IF ----------------
    wait_n   = 2;
    ram_data = 32'h0000002A;
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h00400010;
    bus.mem_req  = 1'b1;
    bus.mem_we   = 1'b0;
    bus.mem_addr = 32'h10010000;
    tick();                                   // cycle 1
    chk("col_ram_addr_c1", bus.ram_addr, 32'h10010000);
    chk("col_ram_req_c1", 32'(bus.ram_req), 32'h1);
    tick();                                   // cycle 2
    tick();                                   // cycle 3 (ack)
    chk("col_mem_done_c3", 32'(bus.mem_done), 32'h0);
    tick();                                   // cycle 4
    chk("col_mem_done_c4", 32'(bus.mem_done), 32'h1);
    chk("col_mem_rdata", bus.mem_rdata, 32'h0000002A);
    chk("col_if_done_c4", 32'(bus.if_done), 32'h0);
    chk("col_stall_c4", 32'(bus.stall), 32'h1);
    chk("col_ram_req_c4", 32'(bus.ram_req), 32'h0);
    bus.mem_req = 1'b0;
    ram_data = 32'h11112222;
    for (int i = 5; i <= 7; i++) begin
      tick();                                 // cycles 5..7
      chk($sformatf("col_stall_c%0d", i), 32'(bus.stall), 32'h1);
      chk($sformatf("col_ram_req_c%0d", i), 32'(bus.ram_req), 32'h1);
      chk($sformatf("col_ram_addr_c%0d", i), bus.ram_addr, 32'h00400010);
    end
    tick();                                   // cycle 8
    chk("col_if_done_c8", 32'(bus.if_done), 32'h1);
    chk("col_if_rdata", bus.if_rdata, 32'h11112222);
    chk("col_stall_c8", 32'(bus.stall), 32'h0);
    bus.if_req = 1'b0;
    tick();

    // ---------------- store ----------------
    wait_n   = 2;
    ram_data = 32'hFFFFFFFF;
    bus.mem_req   = 1'b1;
    bus.mem_we    = 1'b1;
    bus.mem_addr  = 32'h10010004;
    bus.mem_wdata = 32'hDEADBEEF;
    for (int i = 1; i <= 3; i++) begin
      tick();                                 // cycles 1..3
      chk($sformatf("st_ram_we_c%0d", i), 32'(bus.ram_we), 32'h1);
      chk($sformatf("st_ram_addr_c%0d", i), bus.ram_addr, 32'h10010004);
      chk($sformatf("st_ram_wdata_c%0d", i), bus.ram_wdata, 32'hDEADBEEF);
      chk($sformatf("st_mem_done_c%0d", i), 32'(bus.mem_done), 32'h0);
    end
    tick();                                   // cycle 4
    chk("st_mem_done_c4", 32'(bus.mem_done), 32'h1);
    chk("st_mem_rdata", bus.mem_rdata, 32'h0000002A);
    chk("st_ram_we_c4", 32'(bus.ram_we), 32'h0);
    chk("st_ram_req_c4", 32'(bus.ram_req), 32'h0);
    bus.mem_req = 1'b0;
    bus.mem_we  = 1'b0;
    tick();

    // ---------------- flush mid-fetch ----------------
    wait_n   = 4;
    ram_data = 32'h12345678;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h00400020;
    tick();                                   // cycle 1: GNT_IF entry
    chk("fl_ram_req_c1", 32'(bus.ram_req), 32'h1);
    tick();                                   // cycle 2: flush
    bus.flush  = 1'b1;
    bus.if_req = 1'b0;
    #1 chk("fl_stall_c2", 32'(bus.stall), 32'h0);
    tick();                                   // cycle 3
    bus.flush = 1'b0;
    for (int i = 3; i <= 5; i++) begin
      if (i > 3) tick();                      // cycles 4..5
      chk($sformatf("fl_ram_req_c%0d", i), 32'(bus.ram_req), 32'h1);
      chk($sformatf("fl_ram_addr_c%0d", i), bus.ram_addr, 32'h00400020);
      chk($sformatf("fl_if_done_c%0d", i), 32'(bus.if_done), 32'h0);
    end
    tick();                                   // cycle 6
    chk("fl_if_done_c6", 32'(bus.if_done), 32'h0);
    chk("fl_ram_req_c6", 32'(bus.ram_req), 32'h0);
    chk("fl_if_rdata", bus.if_rdata, 32'h11112222);
    tick();
    chk("fl_ram_req_c7", 32'(bus.ram_req), 32'h0);

    // ---------------- held request ----------------
    wait_n   = 1;
    ram_data = 32'hCAFEF00D;
    g0 = n_grant;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h00400030;
    tick();                                   // cycle 1
    tick();                                   // cycle 2 (ack)
    tick();                                   // cycle 3
    chk("hd_if_done_c3", 32'(bus.if_done), 32'h1);
    chk("hd_if_rdata", bus.if_rdata, 32'hCAFEF00D);
    tick();                                   // cycle 4, request still held
    chk("hd_ram_req_c4", 32'(bus.ram_req), 32'h0);
    chk("hd_if_done_c4", 32'(bus.if_done), 32'h0);
    bus.if_req = 1'b0;
    tick();
    tick();
    chk("hd_grants", 32'(n_grant - g0), 32'h1);

    // ---------------- timeout and async reset ----------------
    ram_en = 1'b0;
    bus.mem_req  = 1'b1;
    bus.mem_we   = 1'b0;
    bus.mem_addr = 32'h10010008;
    for (int i = 1; i <= 64; i++) tick();     // cycles 1..64
    chk("to_err_c64", 32'(bus.err), 32'h0);
    chk("to_ram_req_c64", 32'(bus.ram_req), 32'h1);
    tick();                                   // cycle 65
    chk("to_err_c65", 32'(bus.err), 32'h1);
    chk("to_ram_req_c65", 32'(bus.ram_req), 32'h1);
    repeat (3) tick();
    chk("to_err_sticky", 32'(bus.err), 32'h1);
    #2 nrst = 1'b0;
    #1;
    check_all_zero("ar");
    bus.mem_req = 1'b0;
    ram_en = 1'b1;
    #1 nrst = 1'b1;
    tick();
    tick();
    chk("post_ram_req", 32'(bus.ram_req), 32'h0);
    chk("post_err", 32'(bus.err), 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
